// File: rtl/cla_pkg.sv
// Shared types and constants for the carry-look-ahead adder.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  // Group-level propagate/generate pair exchanged between look-ahead levels
  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

endpackage

// File: rtl/carry_look_ahead_generator_if.sv
// Operand/result bundle for the registered CLA adder.
interface carry_look_ahead_generator_if #(
  parameter int unsigned WIDTH = 4
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             grp_p;
  logic             grp_g;

  modport master (
    output a, b, cin,
    input  sum, cout, grp_p, grp_g
  );

  modport slave (
    input  a, b, cin,
    output sum, cout, grp_p, grp_g
  );

endinterface

// File: rtl/cla_4bit_block.sv
// 4-bit look-ahead slice: flat sum-of-products carries plus group propagate/generate.
module cla_4bit_block
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4,
  output pg_t        pg
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;

  assign p = a ^ b;
  assign g = a & b;

  // Every carry is a flat product sum of the group carry-in, never chained
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
  assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c3, c2, c1, c0};

  assign pg.p = &p;
  assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/carry_look_ahead_generator.sv
// Registered carry-look-ahead adder: {cout,sum} = a + b + cin, one cycle of latency.
module carry_look_ahead_generator
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  carry_look_ahead_generator_if.slave   bus
);

  localparam int unsigned NG = WIDTH / GROUP_W;

  if ((WIDTH % GROUP_W) != 0 || WIDTH == 0) begin : g_width_chk
    $error("carry_look_ahead_generator: WIDTH must be a non-zero multiple of GROUP_W");
  end

  pg_t  [NG-1:0]    grp_pg;
  logic [NG-1:0]    grp_c;
  logic [NG-1:0]    grp_c4;
  logic [WIDTH-1:0] s_c;
  logic             blk_p_c;
  logic             blk_g_c;
  logic             cout_c;

  // Second-level carry into group k as a flat OR of products over group P/G
  function automatic logic lookahead(input int unsigned k, input pg_t [NG-1:0] pg,
                                     input logic ci);
    logic res;
    logic prod;
    res  = ci;
    prod = 1'b0;
    for (int unsigned j = 0; j < k; j++) res = res & pg[j].p;
    for (int unsigned j = 0; j < k; j++) begin
      prod = pg[j].g;
      for (int unsigned m = j + 1; m < k; m++) prod = prod & pg[m].p;
      res = res | prod;
    end
    return res;
  endfunction

  for (genvar i = 0; i < NG; i++) begin : g_blk
    cla_4bit_block u_blk (
      .a  (bus.a[i*GROUP_W +: GROUP_W]),
      .b  (bus.b[i*GROUP_W +: GROUP_W]),
      .c0 (grp_c[i]),
      .s  (s_c[i*GROUP_W +: GROUP_W]),
      .c4 (grp_c4[i]),
      .pg (grp_pg[i])
    );
  end

  always_comb begin
    grp_c   = '0;
    blk_p_c = 1'b1;
    for (int unsigned k = 0; k < NG; k++) begin
      grp_c[k] = lookahead(k, grp_pg, bus.cin);
      blk_p_c  = blk_p_c & grp_pg[k].p;
    end
    // Block generate ignores cin by construction
    blk_g_c = lookahead(NG, grp_pg, 1'b0);
    cout_c  = grp_c4[NG-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum   <= '0;
      bus.cout  <= 1'b0;
      bus.grp_p <= 1'b0;
      bus.grp_g <= 1'b0;
    end else begin
      bus.sum   <= s_c;
      bus.cout  <= cout_c;
      bus.grp_p <= blk_p_c;
      bus.grp_g <= blk_g_c;
    end
  end

endmodule

// File: tb/tb_carry_look_ahead_generator.sv
// Self-checking bench: 4-bit directed vectors and 16-bit randomized vectors vs integer addition.
module tb_carry_look_ahead_generator;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carry_look_ahead_generator_if #(.WIDTH(4))  if4  ();
  carry_look_ahead_generator_if #(.WIDTH(16)) if16 ();

  carry_look_ahead_generator #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  carry_look_ahead_generator #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer addition captured at the sampling edge
  logic [4:0]  exp4_q;
  logic        gp4_q, gg4_q;
  logic [16:0] exp16_q;
  logic        gp16_q, gg16_q;
  logic        vld_q = 1'b0;

  always @(posedge clk) begin
    exp4_q  <= 5'(if4.a) + 5'(if4.b) + 5'(if4.cin);
    gp4_q   <= &(if4.a ^ if4.b);
    gg4_q   <= (5'(if4.a) + 5'(if4.b)) > 5'd15;
    exp16_q <= 17'(if16.a) + 17'(if16.b) + 17'(if16.cin);
    gp16_q  <= &(if16.a ^ if16.b);
    gg16_q  <= (17'(if16.a) + 17'(if16.b)) > 17'd65535;
    vld_q   <= rst_n;
  end

  always @(negedge clk) begin
    if (vld_q && rst_n) begin
      chk("m_sum4",   32'(if4.sum),   32'(exp4_q[3:0]));
      chk("m_cout4",  32'(if4.cout),  32'(exp4_q[4]));
      chk("m_gp4",    32'(if4.grp_p), 32'(gp4_q));
      chk("m_gg4",    32'(if4.grp_g), 32'(gg4_q));
      chk("m_sum16",  32'(if16.sum),  32'(exp16_q[15:0]));
      chk("m_cout16", 32'(if16.cout), 32'(exp16_q[16]));
      chk("m_gp16",   32'(if16.grp_p), 32'(gp16_q));
      chk("m_gg16",   32'(if16.grp_g), 32'(gg16_q));
    end
  end

  task automatic dir4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] es, input logic ec);
    if4.a = a; if4.b = b; if4.cin = ci;
    @(posedge clk); #1;
    chk("d_sum4",  32'(if4.sum),  32'(es));
    chk("d_cout4", 32'(if4.cout), 32'(ec));
  endtask

  task automatic dir16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic [15:0] es, input logic ec);
    if16.a = a; if16.b = b; if16.cin = ci;
    @(posedge clk); #1;
    chk("d_sum16",  32'(if16.sum),  32'(es));
    chk("d_cout16", 32'(if16.cout), 32'(ec));
  endtask

  initial begin
    if4.a = '0; if4.b = '0; if4.cin = 1'b0;
    if16.a = '0; if16.b = '0; if16.cin = 1'b0;
    #2;
    chk("rst_sum4",   32'(if4.sum),   32'h0);
    chk("rst_cout4",  32'(if4.cout),  32'h0);
    chk("rst_sum16",  32'(if16.sum),  32'h0);
    chk("rst_gg16",   32'(if16.grp_g), 32'h0);
    if4.a = 4'hF; if4.cin = 1'b1;
    @(posedge clk); #1;
    chk("rst_hold_sum4",  32'(if4.sum),  32'h0);
    chk("rst_hold_cout4", 32'(if4.cout), 32'h0);
    rst_n = 1'b1;

    dir4(4'b1010, 4'b0111, 1'b0, 4'b0001, 1'b1);
    dir4(4'b1100, 4'b1110, 1'b1, 4'b1011, 1'b1);
    dir4(4'b0110, 4'b1001, 1'b0, 4'b1111, 1'b0);
    chk("d_gp4", 32'(if4.grp_p), 32'h1);
    dir4(4'b1000, 4'b0010, 1'b1, 4'b1011, 1'b0);
    dir4(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
    dir4(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);
    dir16(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    dir16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    dir16(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    if16.a = 16'hFFFF; if16.b = 16'h0000; if16.cin = 1'b1;
    dir4(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
    chk("d_full16_sum",  32'(if16.sum),  32'h0);
    chk("d_full16_cout", 32'(if16.cout), 32'h1);

    // Mid-cycle reset must clear the outputs without a clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum4",   32'(if4.sum),   32'h0);
    chk("arst_cout4",  32'(if4.cout),  32'h0);
    chk("arst_sum16",  32'(if16.sum),  32'h0);
    chk("arst_cout16", 32'(if16.cout), 32'h0);
    @(posedge clk); #1;
    chk("arst_hold16", 32'(if16.cout), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      if4.a    = 4'($urandom);
      if4.b    = 4'($urandom);
      if4.cin  = 1'($urandom);
      if16.a   = 16'($urandom);
      if16.b   = 16'($urandom);
      if16.cin = 1'($urandom);
      if ((i % 64) == 5) if16.b = ~if16.a;
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
